// File: rtl/and_checker.sv
// and_checker: self-checking harness for an external AND device.
// Drives nothing itself; it watches the x/y stimulus and the device output z,
// compares z against x&y after LATENCY cycles, and reports pass, mismatch count
// and the index of the first mismatching sample through a valid/ready report.
// Optional feature: define CHECKER_STOP_ON_ERR_EN to end the run at the first mismatch.
module and_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             report_valid,
    input  logic             report_ready,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL1 = '1;
    localparam logic [1:0] DRAIN_INIT = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] sample_idx;
    logic [CNT_W-1:0] num_lat;
    logic [1:0]       drain_cnt;

    // Entry arriving at the compare point this cycle
    logic             cmp_vld;
    logic             cmp_exp;
    logic [CNT_W-1:0] cmp_idx;

    logic             mm_hit;
    logic             stop_hit;
    logic             capture;
    logic             flush;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] first_next;

    // Saturating increment so the mismatch count never wraps back to zero
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == ALL1) ? v : v + ONE;
    endfunction

    // Mismatch detection and the next values of the result registers
    always_comb begin
        mm_hit     = 1'b0;
        cnt_next   = mismatch_count;
        first_next = first_err_idx;
        if ((state == RUN || state == DRAIN) && cmp_vld && (cmp_exp != z)) begin
            mm_hit   = 1'b1;
            cnt_next = sat_inc(mismatch_count);
            if (mismatch_count == '0) begin
                first_next = cmp_idx;
            end
        end
    end

`ifdef CHECKER_STOP_ON_ERR_EN
    assign stop_hit = mm_hit && (mismatch_count == '0);
`else
    assign stop_hit = 1'b0;
`endif

    assign capture = (state == RUN) && !stop_hit;
    assign flush   = stop_hit;

    generate
        if (LATENCY == 0) begin : g_direct
            assign cmp_vld = (state == RUN);
            assign cmp_exp = x & y;
            assign cmp_idx = sample_idx;
        end else begin : g_dline
            logic             vld_dl [LATENCY];
            logic             exp_dl [LATENCY];
            logic [CNT_W-1:0] idx_dl [LATENCY];

            // Valid bits of the delay line; cleared on reset and on an early stop
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < LATENCY; i++) vld_dl[i] <= 1'b0;
                end else begin
                    vld_dl[0] <= capture;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_dl[i] <= flush ? 1'b0 : vld_dl[i-1];
                    end
                end
            end

            // Expected bit and sample index travel alongside their valid bit
            always_ff @(posedge clock) begin
                exp_dl[0] <= x & y;
                idx_dl[0] <= sample_idx;
                for (int i = 1; i < LATENCY; i++) begin
                    exp_dl[i] <= exp_dl[i-1];
                    idx_dl[i] <= idx_dl[i-1];
                end
            end

            assign cmp_vld = vld_dl[LATENCY-1];
            assign cmp_exp = exp_dl[LATENCY-1];
            assign cmp_idx = idx_dl[LATENCY-1];
        end
    endgenerate

    // Run-control FSM with registered status and result outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            report_valid   <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_err_idx  <= ALL1;
            sample_idx     <= '0;
            num_lat        <= '0;
            drain_cnt      <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mismatch_count <= '0;
                        first_err_idx  <= ALL1;
                        sample_idx     <= '0;
                        num_lat        <= num_samples;
                        if (num_samples == '0) begin
                            state        <= REPORT;
                            report_valid <= 1'b1;
                            pass         <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    mismatch_count <= cnt_next;
                    first_err_idx  <= first_next;
                    if (stop_hit) begin
                        state        <= REPORT;
                        busy         <= 1'b0;
                        report_valid <= 1'b1;
                        pass         <= 1'b0;
                    end else if (sample_idx == num_lat - ONE) begin
                        if (LATENCY == 0) begin
                            state        <= REPORT;
                            busy         <= 1'b0;
                            report_valid <= 1'b1;
                            pass         <= (cnt_next == '0);
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end
                    end else begin
                        sample_idx <= sample_idx + ONE;
                    end
                end
                DRAIN: begin
                    mismatch_count <= cnt_next;
                    first_err_idx  <= first_next;
                    if (stop_hit || drain_cnt == 2'd0) begin
                        state        <= REPORT;
                        busy         <= 1'b0;
                        report_valid <= 1'b1;
                        pass         <= (cnt_next == '0);
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                REPORT: begin
                    if (report_ready) begin
                        state        <= IDLE;
                        report_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    report_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
